// File: rtl/mem_bus_arbiter_pkg.sv
// Shared C2 memory-bus encodings, arbiter state enum and default bus geometry.
// Pure declarations; no timing or flow control of its own.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] C2_NOP        = 2'd0;
  localparam logic [1:0] C2_RESPONSE   = 2'd1;
  localparam logic [1:0] C2_READ_LINE  = 2'd2;
  localparam logic [1:0] C2_WRITE_LINE = 2'd3;

  localparam int DEF_ADDR_W  = 15;
  localparam int DEF_DATA_W  = 16;
  localparam int DEF_BEATS   = 8;
  localparam int DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    IDLE,
    WR_SEND,
    WAIT_RSP,
    RD_RECV
  } arb_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// Two-way round-robin picker: on a tie the requester that did not own last wins.
// Combinational, zero latency; no flow control.
module rr_pick2 (
  input  logic [1:0] pend,
  input  logic       last_owner,
  output logic       valid,
  output logic       winner
);

  assign valid  = |pend;
  assign winner = (pend == 2'b11) ? ~last_owner : pend[1];

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one C2 cache-to-memory bus between two line requesters, round-robin, one transaction at a time.
// All outputs registered: grant one cycle after a sampled request, response beats one cycle after mem_rsp; requests simply wait while busy.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [1:0]        req_cmd_0,
  input  logic [ADDR_W-1:0] req_addr_0,
  input  logic [DATA_W-1:0] req_wdata_0,
  output logic              gnt_0,
  output logic              rsp_valid_0,
  output logic              rsp_last_0,
  output logic              rsp_err_0,
  output logic [DATA_W-1:0] rsp_rdata_0,
  input  logic [1:0]        req_cmd_1,
  input  logic [ADDR_W-1:0] req_addr_1,
  input  logic [DATA_W-1:0] req_wdata_1,
  output logic              gnt_1,
  output logic              rsp_valid_1,
  output logic              rsp_last_1,
  output logic              rsp_err_1,
  output logic [DATA_W-1:0] rsp_rdata_1,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [1:0]        mem_rsp,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int BCNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 1);

  arb_state_e              state_q, state_d;
  logic                    owner_q, owner_d;
  logic                    last_owner_q, last_owner_d;
  logic                    is_wr_q, is_wr_d;
  logic [BCNT_W-1:0]       beat_q, beat_d;
  logic [WCNT_W-1:0]       wait_q, wait_d, wait_inc;
  logic [1:0]              gnt_q, gnt_d;
  logic [1:0]              vld_q, vld_d;
  logic [1:0]              last_q, last_d;
  logic [1:0]              err_q, err_d;
  logic [1:0][DATA_W-1:0]  rdata_q, rdata_d;
  logic [1:0]              mem_cmd_q, mem_cmd_d;
  logic [ADDR_W-1:0]       mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]       mem_wdata_q, mem_wdata_d;

  logic                    pick_valid, pick_winner;
  logic [1:0]              sel_cmd;

  rr_pick2 u_pick (
    .pend       ({req_cmd_1 != C2_NOP, req_cmd_0 != C2_NOP}),
    .last_owner (last_owner_q),
    .valid      (pick_valid),
    .winner     (pick_winner)
  );

  assign sel_cmd  = pick_winner ? req_cmd_1 : req_cmd_0;
  // Saturating so a stuck counter can never wrap back under the limit.
  assign wait_inc = (wait_q == WCNT_W'(TIMEOUT)) ? wait_q : wait_q + 1'b1;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    is_wr_d      = is_wr_q;
    beat_d       = beat_q;
    wait_d       = wait_q;
    gnt_d        = '0;
    vld_d        = '0;
    last_d       = '0;
    err_d        = '0;
    rdata_d      = '0;
    mem_cmd_d    = C2_NOP;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          owner_d             = pick_winner;
          last_owner_d        = pick_winner;
          gnt_d[pick_winner]  = 1'b1;
          is_wr_d             = (sel_cmd == C2_WRITE_LINE);
          mem_addr_d          = pick_winner ? req_addr_1 : req_addr_0;
          beat_d              = '0;
          wait_d              = '0;
          if (sel_cmd == C2_WRITE_LINE) begin
            state_d = WR_SEND;
          end else begin
            mem_cmd_d = C2_READ_LINE;
            state_d   = WAIT_RSP;
          end
        end
      end
      WR_SEND: begin
        mem_cmd_d   = C2_WRITE_LINE;
        mem_wdata_d = owner_q ? req_wdata_1 : req_wdata_0;
        if (beat_q == BCNT_W'(BEATS - 1)) begin
          beat_d  = '0;
          wait_d  = '0;
          state_d = WAIT_RSP;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      WAIT_RSP: begin
        // A response on the expiry cycle takes priority over the timeout.
        if (mem_rsp == C2_RESPONSE) begin
          vld_d[owner_q]   = 1'b1;
          rdata_d[owner_q] = is_wr_q ? '0 : mem_rdata;
          if (is_wr_q || beat_q == BCNT_W'(BEATS - 1)) begin
            last_d[owner_q] = 1'b1;
            state_d         = IDLE;
          end else begin
            beat_d  = beat_q + 1'b1;
            state_d = RD_RECV;
          end
        end else begin
          wait_d = wait_inc;
          if (wait_inc == WCNT_W'(TIMEOUT)) begin
            err_d[owner_q] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      RD_RECV: begin
        if (mem_rsp == C2_RESPONSE) begin
          vld_d[owner_q]   = 1'b1;
          rdata_d[owner_q] = mem_rdata;
          if (beat_q == BCNT_W'(BEATS - 1)) begin
            last_d[owner_q] = 1'b1;
            beat_d          = '0;
            state_d         = IDLE;
          end else begin
            beat_d = beat_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q      <= IDLE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      is_wr_q      <= 1'b0;
      beat_q       <= '0;
      wait_q       <= '0;
      gnt_q        <= '0;
      vld_q        <= '0;
      last_q       <= '0;
      err_q        <= '0;
      rdata_q      <= '0;
      mem_cmd_q    <= C2_NOP;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      is_wr_q      <= is_wr_d;
      beat_q       <= beat_d;
      wait_q       <= wait_d;
      gnt_q        <= gnt_d;
      vld_q        <= vld_d;
      last_q       <= last_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign gnt_0       = gnt_q[0];
  assign gnt_1       = gnt_q[1];
  assign rsp_valid_0 = vld_q[0];
  assign rsp_valid_1 = vld_q[1];
  assign rsp_last_0  = last_q[0];
  assign rsp_last_1  = last_q[1];
  assign rsp_err_0   = err_q[0];
  assign rsp_err_1   = err_q[1];
  assign rsp_rdata_0 = rdata_q[0];
  assign rsp_rdata_1 = rdata_q[1];
  assign mem_cmd     = mem_cmd_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: expected grants, write beats, response beats and
// error pulses are queued as stimulus is driven and checked as the DUT produces them.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int ADDR_W  = 15;
  localparam int DATA_W  = 16;
  localparam int BEATS   = 8;
  localparam int TIMEOUT = 255;

  logic              CLK = 1'b0;
  logic              RESET;
  logic [1:0]        req_cmd_0, req_cmd_1;
  logic [ADDR_W-1:0] req_addr_0, req_addr_1;
  logic [DATA_W-1:0] req_wdata_0, req_wdata_1;
  logic              gnt_0, gnt_1;
  logic              rsp_valid_0, rsp_valid_1, rsp_last_0, rsp_last_1, rsp_err_0, rsp_err_1;
  logic [DATA_W-1:0] rsp_rdata_0, rsp_rdata_1;
  logic [1:0]        mem_cmd, mem_rsp;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BEATS(BEATS), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_cmd_0(req_cmd_0), .req_addr_0(req_addr_0), .req_wdata_0(req_wdata_0),
    .gnt_0(gnt_0), .rsp_valid_0(rsp_valid_0), .rsp_last_0(rsp_last_0),
    .rsp_err_0(rsp_err_0), .rsp_rdata_0(rsp_rdata_0),
    .req_cmd_1(req_cmd_1), .req_addr_1(req_addr_1), .req_wdata_1(req_wdata_1),
    .gnt_1(gnt_1), .rsp_valid_1(rsp_valid_1), .rsp_last_1(rsp_last_1),
    .rsp_err_1(rsp_err_1), .rsp_rdata_1(rsp_rdata_1),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp(mem_rsp), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  typedef struct { logic port; logic [1:0] cmd; logic [ADDR_W-1:0] addr; } gnt_exp_t;
  typedef struct { logic port; logic [DATA_W-1:0] data; logic last; } rsp_exp_t;
  typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } wr_exp_t;

  gnt_exp_t gq[$];
  rsp_exp_t rq[$];
  wr_exp_t  wq[$];
  logic     eq[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   gnt_cyc = 0, rsp_cyc = 0, err_cyc = 0, g_ref = 0;
  logic gnt_seen = 1'b0, rsp_seen = 1'b0, err_seen = 1'b0, rd_follow = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_gnt"}, {gnt_1, gnt_0}, 0);
    chk({tag, "_rsp"}, {rsp_valid_1, rsp_valid_0, rsp_last_1, rsp_last_0, rsp_err_1, rsp_err_0}, 0);
    chk({tag, "_rdata"}, {rsp_rdata_1, rsp_rdata_0}, 0);
    chk({tag, "_mem_cmd"}, mem_cmd, C2_NOP);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
  endtask

  // Advance one cycle, then check every DUT output against the scoreboard queues.
  task automatic tick();
    gnt_exp_t g; rsp_exp_t r; wr_exp_t w; logic e;
    @(posedge CLK); #1;
    cyc++;
    gnt_seen = gnt_0 | gnt_1;
    rsp_seen = rsp_valid_0 | rsp_valid_1;
    err_seen = rsp_err_0 | rsp_err_1;
    if (rd_follow) chk("rd_cmd_one_cycle", mem_cmd, C2_NOP);
    rd_follow = 1'b0;
    if (gnt_seen) begin
      gnt_cyc = cyc;
      if (gq.size() == 0) chk("gnt_unexpected", {gnt_1, gnt_0}, 0);
      else begin
        g = gq.pop_front();
        chk("gnt_port", {gnt_1, gnt_0}, g.port ? 2'b10 : 2'b01);
        if (g.cmd == C2_READ_LINE) begin
          chk("rd_cmd", mem_cmd, C2_READ_LINE);
          chk("rd_addr", mem_addr, g.addr);
          rd_follow = 1'b1;
        end else chk("wr_gnt_cmd", mem_cmd, C2_NOP);
      end
    end else if (mem_cmd == C2_READ_LINE) chk("rd_cmd_stray", mem_cmd, C2_NOP);
    if (mem_cmd == C2_WRITE_LINE) begin
      if (wq.size() == 0) chk("wr_unexpected", mem_cmd, C2_NOP);
      else begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_wdata, w.data);
      end
    end
    if (rsp_seen) begin
      rsp_cyc = cyc;
      if (rq.size() == 0) chk("rsp_unexpected", {rsp_valid_1, rsp_valid_0}, 0);
      else begin
        r = rq.pop_front();
        chk("rsp_port", {rsp_valid_1, rsp_valid_0}, r.port ? 2'b10 : 2'b01);
        chk("rsp_data", r.port ? rsp_rdata_1 : rsp_rdata_0, r.data);
        chk("rsp_last", r.port ? rsp_last_1 : rsp_last_0, r.last);
      end
    end
    if (!rsp_valid_0) chk("quiet0", {rsp_last_0, rsp_rdata_0}, 0);
    if (!rsp_valid_1) chk("quiet1", {rsp_last_1, rsp_rdata_1}, 0);
    if (err_seen) begin
      err_cyc = cyc;
      if (eq.size() == 0) chk("err_unexpected", {rsp_err_1, rsp_err_0}, 0);
      else begin
        e = eq.pop_front();
        chk("err_port", {rsp_err_1, rsp_err_0}, e ? 2'b10 : 2'b01);
      end
    end
  endtask

  task automatic wait_gnt(input int budget);
    int n = 0;
    gnt_seen = 1'b0;
    while (!gnt_seen && n < budget) begin
      tick();
      n++;
    end
    chk("gnt_arrived", gnt_seen, 1);
  endtask

  // Memory returns n beats base, base+1, ...; optional one-cycle NOP stall before beat stall_at.
  task automatic mem_burst(input logic port, input logic [DATA_W-1:0] base, input int n, input int stall_at);
    rsp_exp_t r;
    for (int k = 0; k < n; k++) begin
      if (k == stall_at) begin
        mem_rsp = C2_NOP;
        tick();
        chk("stall_quiet", rsp_seen, 0);
      end
      mem_rsp   = C2_RESPONSE;
      mem_rdata = base + DATA_W'(k);
      r.port = port; r.data = mem_rdata; r.last = (k == n - 1);
      rq.push_back(r);
      tick();
      chk("rsp_latency", rsp_seen, 1);
    end
    mem_rsp   = C2_NOP;
    mem_rdata = '0;
  endtask

  function automatic gnt_exp_t ge(input logic port, input logic [1:0] cmd, input logic [ADDR_W-1:0] addr);
    ge.port = port; ge.cmd = cmd; ge.addr = addr;
  endfunction

  initial begin
    wr_exp_t w;
    RESET = 1'b0;
    req_cmd_0 = C2_NOP; req_addr_0 = '0; req_wdata_0 = '0;
    req_cmd_1 = C2_NOP; req_addr_1 = '0; req_wdata_1 = '0;
    mem_rsp = C2_NOP; mem_rdata = '0;
    tick(); tick();
    chk_quiet("reset");
    RESET = 1'b1;
    tick();

    // Single read from requester 0.
    gq.push_back(ge(1'b0, C2_READ_LINE, 15'h1234));
    req_cmd_0 = C2_READ_LINE; req_addr_0 = 15'h1234;
    wait_gnt(10);
    req_cmd_0 = C2_NOP;
    tick(); tick();
    mem_burst(1'b0, 16'hA000, BEATS, -1);
    tick(); tick();

    // Single write from requester 1.
    gq.push_back(ge(1'b1, C2_WRITE_LINE, 15'h0042));
    for (int k = 0; k < BEATS; k++) begin
      w.addr = 15'h0042; w.data = 16'h0100 + 16'(k);
      wq.push_back(w);
    end
    req_cmd_1 = C2_WRITE_LINE; req_addr_1 = 15'h0042; req_wdata_1 = 16'h0100;
    wait_gnt(10);
    req_cmd_1 = C2_NOP;
    for (int k = 1; k < BEATS; k++) begin
      tick();
      req_wdata_1 = 16'h0100 + 16'(k);
    end
    tick();
    chk("wr_beats_done", wq.size(), 0);
    tick(); tick();
    chk("wr_no_extra", mem_cmd, C2_NOP);
    mem_burst(1'b1, 16'h0000, 1, -1);
    tick();

    // Tie from reset, then again: r0, r1, r0, r1.
    RESET = 1'b0;
    tick();
    RESET = 1'b1;
    gq.push_back(ge(1'b0, C2_READ_LINE, 15'h0100));
    gq.push_back(ge(1'b1, C2_READ_LINE, 15'h0200));
    gq.push_back(ge(1'b0, C2_READ_LINE, 15'h0110));
    gq.push_back(ge(1'b1, C2_READ_LINE, 15'h0210));
    req_cmd_0 = C2_READ_LINE; req_addr_0 = 15'h0100;
    req_cmd_1 = C2_READ_LINE; req_addr_1 = 15'h0200;
    wait_gnt(10);
    req_cmd_0 = C2_NOP;
    tick();
    mem_burst(1'b0, 16'hD000, BEATS, 4);
    wait_gnt(10);
    chk("b2b_gnt_after_last", gnt_cyc - rsp_cyc, 1);
    req_cmd_1 = C2_NOP;
    req_cmd_0 = C2_READ_LINE; req_addr_0 = 15'h0110;
    tick(); tick();
    req_cmd_1 = C2_READ_LINE; req_addr_1 = 15'h0210;
    mem_burst(1'b1, 16'hE000, BEATS, -1);
    wait_gnt(10);
    req_cmd_0 = C2_NOP;
    mem_burst(1'b0, 16'hD100, BEATS, -1);
    wait_gnt(10);
    req_cmd_1 = C2_NOP;
    mem_burst(1'b1, 16'hE100, BEATS, 2);
    tick();

    // Silent memory: timeout on r0, while r1 waits for the bus.
    gq.push_back(ge(1'b0, C2_READ_LINE, 15'h0777));
    req_cmd_0 = C2_READ_LINE; req_addr_0 = 15'h0777;
    wait_gnt(10);
    g_ref = gnt_cyc;
    req_cmd_0 = C2_NOP;
    gq.push_back(ge(1'b1, C2_READ_LINE, 15'h0333));
    req_cmd_1 = C2_READ_LINE; req_addr_1 = 15'h0333;
    eq.push_back(1'b0);
    err_seen = 1'b0;
    for (int n = 0; n < TIMEOUT + 10 && !err_seen; n++) tick();
    chk("err_seen", err_seen, 1);
    chk("timeout_cycles", err_cyc - g_ref, TIMEOUT);
    wait_gnt(10);
    chk("gnt_after_err", gnt_cyc - err_cyc, 1);
    req_cmd_1 = C2_NOP;
    mem_burst(1'b1, 16'hC000, BEATS, -1);
    tick();

    // Response arriving exactly on the expiry cycle wins over the timeout.
    gq.push_back(ge(1'b0, C2_READ_LINE, 15'h0888));
    req_cmd_0 = C2_READ_LINE; req_addr_0 = 15'h0888;
    wait_gnt(10);
    req_cmd_0 = C2_NOP;
    for (int n = 0; n < TIMEOUT - 1; n++) tick();
    mem_burst(1'b0, 16'hB000, BEATS, -1);
    tick(); tick();

    // Reset asserted while write beat 3 is on the bus.
    gq.push_back(ge(1'b0, C2_WRITE_LINE, 15'h0055));
    for (int k = 0; k < 4; k++) begin
      w.addr = 15'h0055; w.data = 16'h0300 + 16'(k);
      wq.push_back(w);
    end
    req_cmd_0 = C2_WRITE_LINE; req_addr_0 = 15'h0055; req_wdata_0 = 16'h0300;
    wait_gnt(10);
    req_cmd_0 = C2_NOP;
    for (int k = 1; k < 4; k++) begin
      tick();
      req_wdata_0 = 16'h0300 + 16'(k);
    end
    tick();
    chk("beat3_on_bus", mem_wdata, 16'h0303);
    #2 RESET = 1'b0;
    #1 chk_quiet("mid_reset");
    tick(); tick();
    RESET = 1'b1;
    tick();
    gq.push_back(ge(1'b0, C2_READ_LINE, 15'h0ABC));
    req_cmd_0 = C2_READ_LINE; req_addr_0 = 15'h0ABC;
    wait_gnt(10);
    req_cmd_0 = C2_NOP;
    mem_burst(1'b0, 16'hF000, BEATS, 3);
    tick(); tick(); tick();

    chk("gq_empty", gq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    chk("eq_empty", eq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
